serializer_tx: RTL and testbench

Parallel-in, serial-out transmitter built on the team's D flip-flop storage style. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, framed by a busy flag. It then pulses done for one cycle. It is the sending end of the serial link whose receiving end captures bits into flip-flops, and it sits between FSM datapath logic and that link.

---
 rtl/serializer_tx_if.sv | 35 +++
 rtl/serializer_tx.sv | 128 ++++++++++++
 tb/tb_serializer_tx.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serializer_tx_if.sv
// Load handshake and serial link bundle for serializer_tx.
//   load_valid / load_data : word offered by the upstream datapath
//   load_ready             : transmitter can take a word this cycle
//   serial_out             : serial data bit toward the receiver
//   frame                  : high while a data bit is on serial_out
//   done                   : one-cycle pulse after the last bit
// master = upstream producer / link observer, slave = serializer_tx.
interface serializer_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             serial_out;
   logic             frame;
   logic             done;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  serial_out,
      input  frame,
      input  done
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output serial_out,
      output frame,
      output done
   );
endinterface

// File: rtl/serializer_tx.sv
// Parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word on a valid/ready handshake while idle, then shifts
// it out one bit per enabled clock with frame high, then pulses done for one
// enabled cycle before returning to idle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   en   : clock enable; all state and registered outputs hold when low
//   bus  : serializer_tx_if.slave (load_valid/load_data/load_ready in,
//          serial_out/frame/done out)
module serializer_tx #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter bit          IDLE_LEVEL = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   serializer_tx_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic             sout_q,  sout_d;
   logic             frame_q, frame_d;
   logic             done_q,  done_d;

   logic             accept;

   // Ready is combinational so an idle transmitter can accept on the very
   // edge the word is offered; it follows en even while reset is held.
   assign bus.load_ready = (state_q == IDLE) & en;
   assign accept         = bus.load_valid & bus.load_ready;

   assign bus.serial_out = sout_q;
   assign bus.frame      = frame_q;
   assign bus.done       = done_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      sout_d  = sout_q;
      frame_d = frame_q;
      done_d  = done_q;

      if (en) begin
         case (state_q)
            IDLE: begin
               sout_d  = IDLE_LEVEL;
               frame_d = 1'b0;
               done_d  = 1'b0;
               if (accept) begin
                  // First bit goes out on the accept edge itself.
                  state_d = SHIFT;
                  shreg_d = bus.load_data;
                  cnt_d   = '0;
                  sout_d  = MSB_FIRST ? bus.load_data[WIDTH-1] : bus.load_data[0];
                  frame_d = 1'b1;
               end
            end

            SHIFT: begin
               if (cnt_q == LAST_BIT) begin
                  state_d = DONE;
                  sout_d  = IDLE_LEVEL;
                  frame_d = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  // The bit now on serial_out sits at the leading end of
                  // shreg_q; the next one is its neighbour.
                  cnt_d = cnt_q + 1'b1;
                  if (MSB_FIRST) begin
                     shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                     sout_d  = shreg_q[WIDTH-2];
                  end else begin
                     shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                     sout_d  = shreg_q[1];
                  end
               end
            end

            DONE: begin
               state_d = IDLE;
               done_d  = 1'b0;
               sout_d  = IDLE_LEVEL;
               frame_d = 1'b0;
            end

            default: begin
               state_d = IDLE;
               sout_d  = IDLE_LEVEL;
               frame_d = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         sout_q  <= IDLE_LEVEL;
         frame_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         frame_q <= frame_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_serializer_tx.sv
// Self-checking bench for serializer_tx. Two instances share clock, reset,
// enable and load stimulus: one MSB-first with idle level 0, one LSB-first
// with idle level 1. A frame-position reference model predicts every output.
module tb_serializer_tx;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         en;
   logic         lv;
   logic [W-1:0] ld;

   always #5 clk = ~clk;

   serializer_tx_if #(.WIDTH(W)) bus_m ();
   serializer_tx_if #(.WIDTH(W)) bus_l ();

   assign bus_m.load_valid = lv;
   assign bus_m.load_data  = ld;
   assign bus_l.load_valid = lv;
   assign bus_l.load_data  = ld;

   serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus_m.slave)
   );

   serializer_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .bus (bus_l.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: pos = -1 idle, 0..W-1 index of the bit on the wire
   // (in transmission order), W = done cycle.
   int           pos  = -1;
   logic [W-1:0] word = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic exp_sout(input bit msb_first, input bit idle);
      if (pos >= 0 && pos < W)
         return msb_first ? word[W-1-pos] : word[pos];
      return idle;
   endfunction

   task automatic check_outputs();
      logic rdy;
      rdy = (pos == -1) && en;
      check("msb_sout",  32'(bus_m.serial_out), 32'(exp_sout(1'b1, 1'b0)));
      check("lsb_sout",  32'(bus_l.serial_out), 32'(exp_sout(1'b0, 1'b1)));
      check("msb_frame", 32'(bus_m.frame), 32'(pos >= 0 && pos < W));
      check("lsb_frame", 32'(bus_l.frame), 32'(pos >= 0 && pos < W));
      check("msb_done",  32'(bus_m.done), 32'(pos == W));
      check("lsb_done",  32'(bus_l.done), 32'(pos == W));
      check("msb_ready", 32'(bus_m.load_ready), 32'(rdy));
      check("lsb_ready", 32'(bus_l.load_ready), 32'(rdy));
   endtask

   // Called at a falling edge: apply inputs, check, take one rising edge,
   // advance the model, return at the next falling edge.
   task automatic cycle(input logic v, input logic [W-1:0] d, input logic e);
      logic acc;
      lv = v;
      ld = d;
      en = e;
      #1;
      check_outputs();
      acc = e && v && (pos == -1);
      @(posedge clk);
      if (rst && e) begin
         if (pos == -1) begin
            if (acc) begin
               word = d;
               pos  = 0;
            end
         end else if (pos < W) begin
            pos = pos + 1;
         end else begin
            pos = -1;
         end
      end
      @(negedge clk);
   endtask

   // Asserts reset between edges, checks the immediate effect, holds it
   // across two edges (en low then high), releases it between edges.
   task automatic async_reset();
      #2 rst = 1'b0;
      #1;
      pos = -1;
      check("rst_msb_sout",  32'(bus_m.serial_out), 32'd0);
      check("rst_lsb_sout",  32'(bus_l.serial_out), 32'd1);
      check("rst_msb_frame", 32'(bus_m.frame), 32'd0);
      check("rst_msb_done",  32'(bus_m.done), 32'd0);
      @(negedge clk);
      cycle(1'b1, W'($urandom), 1'b0);
      cycle(1'b1, W'($urandom), 1'b1);
      #2 rst = 1'b1;
      lv = 1'b0;
      @(negedge clk);
   endtask

   // Sends one word with en held high, capturing the serial stream from both
   // instances and checking it against the word itself.
   task automatic send_capture(input logic [W-1:0] d, input bit hold_valid);
      logic [W-1:0] cap_m;
      logic [W-1:0] cap_l;
      cycle(1'b1, d, 1'b1);
      for (int i = 0; i < W; i++) begin
         cap_m[W-1-i] = bus_m.serial_out;
         cap_l[i]     = bus_l.serial_out;
         check("dir_frame", 32'(bus_m.frame), 32'd1);
         cycle(hold_valid, W'($urandom), 1'b1);
      end
      check("dir_msb_word", 32'(cap_m), 32'(d));
      check("dir_lsb_word", 32'(cap_l), 32'(d));
      check("dir_done",  32'(bus_m.done), 32'd1);
      check("dir_ready_in_done", 32'(bus_m.load_ready), 32'd0);
      cycle(hold_valid, W'($urandom), 1'b1);
      check("dir_done_low", 32'(bus_m.done), 32'd0);
      check("dir_ready_back", 32'(bus_m.load_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      lv  = 1'b0;
      ld  = '0;
      @(negedge clk);
      // Reset state, ready following en during reset.
      cycle(1'b1, 8'h55, 1'b0);
      cycle(1'b1, 8'h55, 1'b1);
      #2 rst = 1'b1;
      lv = 1'b0;
      @(negedge clk);
      cycle(1'b0, '0, 1'b1);

      send_capture(8'hA5, 1'b0);
      cycle(1'b0, '0, 1'b1);
      send_capture(8'h01, 1'b0);

      // Enable gap after bit 2 of 8'hF0.
      cycle(1'b1, 8'hF0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 8'h0F, 1'b0);
         check("gap_msb_sout", 32'(bus_m.serial_out), 32'd1);
         check("gap_frame", 32'(bus_m.frame), 32'd1);
      end
      for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1);

      // Reset during bit 4 of 8'hFF, then a clean 8'h3C frame.
      cycle(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      check("pre_rst_frame", 32'(bus_m.frame), 32'd1);
      async_reset();
      check("post_rst_ready", 32'(bus_m.load_ready), 32'd1);
      send_capture(8'h3C, 1'b0);

      // load_valid held with changing data through a whole 8'h81 frame.
      send_capture(8'h81, 1'b1);
      check("hold_reaccept_word", 32'(word), 32'(lv ? 8'h81 : 8'h81));
      for (int i = 0; i < W + 2; i++) cycle(1'b0, '0, 1'b1);

      // Randomized traffic with enable gaps and occasional async resets.
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 59) == 0)
            async_reset();
         else
            cycle(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 7) != 0));
      end
      cycle(1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
